// File: rtl/shift_pkg.sv
// Shared shift-operation encodings and the sequential shifter's state type.
package shift_pkg;

  localparam logic [1:0] OPE_SLL = 2'b00;
  localparam logic [1:0] OPE_SRL = 2'b01;
  localparam logic [1:0] OPE_SRA = 2'b10;
  localparam logic [1:0] OPE_RSV = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_step.sv
// Combinational single-position shift of an N-bit word, selected by ope.
module shift_step
  import shift_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] i_data,
  input  logic [1:0]   i_ope,
  output logic [N-1:0] o_data
);

  always_comb begin
    o_data = i_data;
    case (i_ope)
      OPE_SLL: o_data = {i_data[N-2:0], 1'b0};
      OPE_SRL: o_data = {1'b0, i_data[N-1:1]};
      OPE_SRA: o_data = {i_data[N-1], i_data[N-1:1]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/shift_seq.sv
// Iterative SLL/SRL/SRA shifter: one bit position per clock behind
// valid/ready handshakes on both the request and result sides.
module shift_seq
  import shift_pkg::*;
#(
  parameter int N  = 32,
  parameter int SW = $clog2(N)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic [1:0]   ope_i,
  input  logic         flush_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [N-1:0] res_o,
  output logic         busy_o
);

  shift_state_t  r_state;
  shift_state_t  w_state_next;
  logic [N-1:0]  r_work;
  logic [N-1:0]  w_work_next;
  logic [SW-1:0] r_cnt;
  logic [SW-1:0] w_cnt_next;
  logic [1:0]    r_ope;
  logic [1:0]    w_ope_next;
  logic [N-1:0]  w_step;
  logic [SW-1:0] w_shamt;
  logic          w_unused_b;

  assign w_shamt    = b_i[SW-1:0];
  assign w_unused_b = ^b_i[N-1:SW];

  shift_step #(.N(N)) u_step (
    .i_data (r_work),
    .i_ope  (r_ope),
    .o_data (w_step)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_ope   <= OPE_SLL;
    end else begin
      r_state <= w_state_next;
      r_work  <= w_work_next;
      r_cnt   <= w_cnt_next;
      r_ope   <= w_ope_next;
    end
  end

  // Flush wins over every transition; the work register is left as-is and
  // simply ignored since valid_o drops.
  always_comb begin
    w_state_next = r_state;
    w_work_next  = r_work;
    w_cnt_next   = r_cnt;
    w_ope_next   = r_ope;
    if (flush_i) begin
      w_state_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (valid_i) begin
            w_work_next = a_i;
            w_cnt_next  = w_shamt;
            w_ope_next  = ope_i;
            if (ope_i == OPE_RSV) begin
              w_work_next  = '0;
              w_state_next = DONE;
            end else if (w_shamt == '0) begin
              w_state_next = DONE;
            end else begin
              w_state_next = SHIFT;
            end
          end
        end
        SHIFT: begin
          w_work_next = w_step;
          w_cnt_next  = r_cnt - 1'b1;
          if (r_cnt == SW'(1)) w_state_next = DONE;
        end
        DONE: begin
          if (ready_i) w_state_next = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign ready_o = rst_ni && (r_state == IDLE);
  assign valid_o = (r_state == DONE);
  assign busy_o  = (r_state != IDLE);
  assign res_o   = r_work;

endmodule
